// File: rtl/x_usr_access_capture_pkg.sv
// rtl/x_usr_access_capture_pkg.sv - shared state encoding and counter width for the USR_ACCESS reader
package x_usr_access_capture_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    QUAL = 2'd1,
    HOLD = 2'd2,
    LOCK = 2'd3
  } state_t;

endpackage

// File: rtl/x_usr_access_sync.sv
// rtl/x_usr_access_sync.sv - async-reset multi-flop synchroniser chain
module x_usr_access_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] chain [STAGES];

  // Shift the asynchronous input through STAGES flops; chain clears on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) chain[i] <= '0;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/x_usr_access_capture.sv
// rtl/x_usr_access_capture.sv - qualifies the USR_ACCESS word and hands it to a consumer
module x_usr_access_capture
  import x_usr_access_capture_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter     LOC           = "UNPLACED"
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        DATAVALID_IN,
  input  logic [31:0] DATA_IN,
  output logic [31:0] O_DATA,
  output logic        O_VALID,
  input  logic        O_READY,
  output logic        CHANGED,
  output logic        LOCKED
);

  localparam logic [CNT_W-1:0] STABLE = CNT_W'(STABLE_CYCLES);

  // LOC is a placement attribute only; it is referenced here so it rides on the instance
  if ($bits(LOC) == 0) begin : g_loc
  end

  logic             dv_s;
  logic [31:0]      d_s;
  logic [31:0]      d_p;
  logic             equal;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             have_word;
  state_t           state;

  x_usr_access_sync #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_sync_dv (
    .clk (CLK),
    .rst (RST),
    .d   (DATAVALID_IN),
    .q   (dv_s)
  );

  x_usr_access_sync #(.WIDTH(32), .STAGES(SYNC_STAGES)) u_sync_data (
    .clk (CLK),
    .rst (RST),
    .d   (DATA_IN),
    .q   (d_s)
  );

  assign equal   = (d_s == d_p);
  assign cnt_inc = (cnt == STABLE) ? cnt : cnt + 1'b1;

  // One-cycle delayed copy of the synced word for the stability compare
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) d_p <= '0;
    else     d_p <= d_s;
  end

  // Qualification FSM with stable counter, accepted-word flag and registered outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      cnt       <= '0;
      have_word <= 1'b0;
      O_DATA    <= '0;
      O_VALID   <= 1'b0;
      CHANGED   <= 1'b0;
      LOCKED    <= 1'b0;
    end else begin
      CHANGED <= 1'b0;
      LOCKED  <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (dv_s) state <= QUAL;
        end
        QUAL: begin
          if (!dv_s) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (!equal) begin
            cnt <= '0;
          end else if (cnt_inc == STABLE) begin
            cnt <= STABLE;
            if (have_word && (d_s == O_DATA)) begin
              // Same word as last delivered: relock silently
              state  <= LOCK;
              LOCKED <= 1'b1;
            end else begin
              O_DATA    <= d_s;
              O_VALID   <= 1'b1;
              CHANGED   <= have_word;
              have_word <= 1'b1;
              state     <= HOLD;
            end
          end else begin
            cnt <= cnt_inc;
          end
        end
        HOLD: begin
          // Word stays offered regardless of dv_s until the consumer takes it
          if (O_READY) begin
            O_VALID <= 1'b0;
            state   <= LOCK;
            LOCKED  <= dv_s && (d_s == O_DATA);
          end
        end
        LOCK: begin
          if (!dv_s) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (d_s != O_DATA) begin
            state <= QUAL;
            cnt   <= '0;
          end else begin
            LOCKED <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_x_usr_access_capture.sv
// tb/tb_x_usr_access_capture.sv - directed and scoreboarded bench for x_usr_access_capture
module tb_x_usr_access_capture;
  import x_usr_access_capture_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dv, dv6;
  logic [31:0] din, din6;
  logic        ordy, rdy6;
  logic [31:0] odata, odata6;
  logic        ovalid, ovalid6;
  logic        chg, chg6;
  logic        lck, lck6;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];
  logic [31:0] exp6_q[$];

  always #5 clk = ~clk;

  x_usr_access_capture dut (
    .CLK          (clk),
    .RST          (rst),
    .DATAVALID_IN (dv),
    .DATA_IN      (din),
    .O_DATA       (odata),
    .O_VALID      (ovalid),
    .O_READY      (ordy),
    .CHANGED      (chg),
    .LOCKED       (lck)
  );

  x_usr_access_capture #(.SYNC_STAGES(3), .STABLE_CYCLES(1)) dut6 (
    .CLK          (clk),
    .RST          (rst),
    .DATAVALID_IN (dv6),
    .DATA_IN      (din6),
    .O_DATA       (odata6),
    .O_VALID      (ovalid6),
    .O_READY      (rdy6),
    .CHANGED      (chg6),
    .LOCKED       (lck6)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard for the default instance: pop on every handshake
  always begin
    @(negedge clk);
    #2;
    if (!rst && ovalid && ordy) begin
      n_checks++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL sb_unexpected: observed %h expected no word", odata);
      end
      if (exp_q.size() != 0) check("sb_word", odata, exp_q.pop_front());
    end
  end

  // Scoreboard for the SYNC_STAGES=3 / STABLE_CYCLES=1 instance
  always begin
    @(negedge clk);
    #2;
    if (!rst && ovalid6 && rdy6) begin
      n_checks++;
      assert (exp6_q.size() != 0) else begin
        n_fail++;
        $error("FAIL sb6_unexpected: observed %h expected no word", odata6);
      end
      if (exp6_q.size() != 0) check("sb6_word", odata6, exp6_q.pop_front());
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    logic [31:0] last;
    bit          seen;

    dv = 1'b0; din = '0; ordy = 1'b0;
    dv6 = 1'b0; din6 = '0; rdy6 = 1'b1;

    // Reset state
    step(2);
    check("rst_valid", ovalid, 0);
    check("rst_data", odata, 0);
    check("rst_changed", chg, 0);
    check("rst_locked", lck, 0);
    check("rst_valid6", ovalid6, 0);
    #1 rst = 1'b0;
    step(1);

    // T2 basic acceptance
    #1 dv = 1'b1; din = 32'hDEADBEEF; ordy = 1'b1; exp_q.push_back(32'hDEADBEEF);
    step(6);
    check("t2_not_early", ovalid, 0);
    step(1);
    check("t2_valid_edge7", ovalid, 1);
    check("t2_data", odata, 32'hDEADBEEF);
    check("t2_no_changed", chg, 0);
    step(1);
    check("t2_valid_one_cycle", ovalid, 0);
    check("t2_locked", lck, 1);

    // T3 one-cycle glitch to zero during qualification
    #1 din = 32'hA5A5A5A5; exp_q.push_back(32'hA5A5A5A5);
    step(4);
    #1 din = 32'h0;
    step(1);
    #1 din = 32'hA5A5A5A5;
    for (int e = 6; e <= 11; e++) begin
      step(1);
      check("t3_no_early_accept", ovalid, 0);
      check("t3_data_held", odata, 32'hDEADBEEF);
    end
    step(1);
    check("t3_valid_after_restart", ovalid, 1);
    check("t3_data", odata, 32'hA5A5A5A5);
    check("t3_changed", chg, 1);
    step(1);
    check("t3_locked", lck, 1);
    check("t3_changed_one_cycle", chg, 0);

    // T4 backpressure with a word change while held
    #1 ordy = 1'b0; din = 32'hDEADBEEF; exp_q.push_back(32'hDEADBEEF);
    step(7);
    check("t4_valid", ovalid, 1);
    check("t4_data", odata, 32'hDEADBEEF);
    check("t4_changed", chg, 1);
    step(2);
    #1 din = 32'h12345678; exp_q.push_back(32'h12345678);
    step(18);
    check("t4_valid_held", ovalid, 1);
    check("t4_data_held", odata, 32'hDEADBEEF);
    check("t4_not_locked", lck, 0);
    check("t4_no_changed_in_hold", chg, 0);
    #1 ordy = 1'b1;
    step(1);
    check("t4_handshake_clears", ovalid, 0);
    step(4);
    check("t4_requal_not_early", ovalid, 0);
    step(1);
    check("t4_new_valid", ovalid, 1);
    check("t4_new_data", odata, 32'h12345678);
    check("t4_new_changed", chg, 1);
    step(1);
    check("t4_new_delivered", ovalid, 0);
    check("t4_new_locked", lck, 1);

    // T5 DATAVALID dropout in QUAL, then reassert with the delivered word
    #1 din = 32'hCAFEF00D;
    step(3);
    #1 dv = 1'b0;
    for (int i = 0; i < 9; i++) begin
      step(1);
      check("t5_no_valid", ovalid, 0);
      check("t5_no_changed", chg, 0);
    end
    #1 dv = 1'b1; din = 32'h12345678;
    for (int i = 1; i <= 6; i++) begin
      step(1);
      check("t5_reassert_no_valid", ovalid, 0);
      check("t5_reassert_not_locked", lck, 0);
    end
    step(1);
    check("t5_relocked", lck, 1);
    check("t5_relock_no_valid", ovalid, 0);
    check("t5_relock_no_changed", chg, 0);

    // T1 reset in the middle of a pending handshake
    #1 ordy = 1'b0; din = 32'h0BADF00D;
    step(7);
    check("t1_hold_valid", ovalid, 1);
    check("t1_hold_data", odata, 32'h0BADF00D);
    #1 rst = 1'b1;
    #1;
    check("t1_rst_valid", ovalid, 0);
    check("t1_rst_data", odata, 0);
    check("t1_rst_locked", lck, 0);
    check("t1_rst_changed", chg, 0);
    step(2);
    #1 rst = 1'b0; ordy = 1'b1; exp_q.push_back(32'h0BADF00D);
    step(1);
    check("t1_state_idle", 32'(dut.state), 32'(IDLE));
    step(5);
    check("t1_not_early", ovalid, 0);
    step(1);
    check("t1_valid_again", ovalid, 1);
    check("t1_data_again", odata, 32'h0BADF00D);
    check("t1_first_after_reset_no_changed", chg, 0);
    step(1);
    check("t1_locked", lck, 1);

    // T6 SYNC_STAGES=3, STABLE_CYCLES=1 latency and random async words
    #1 dv6 = 1'b1; din6 = 32'hC0FFEE00; exp6_q.push_back(32'hC0FFEE00);
    step(4);
    check("t6_not_early", ovalid6, 0);
    step(1);
    check("t6_valid_edge5", ovalid6, 1);
    check("t6_data", odata6, 32'hC0FFEE00);
    last = 32'hC0FFEE00;
    for (int k = 0; k < 16; k++) begin
      step(2);
      w = $urandom;
      if (w == last) w = ~w;
      #($urandom_range(1, 4));
      din6 = w;
      exp6_q.push_back(w);
      last = w;
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
        step(1);
        if (ovalid6) seen = 1'b1;
      end
      check("t6_word_presented", 32'(seen), 1);
      check("t6_changed", chg6, 1);
    end

    step(4);
    check("sb_drained", 32'(exp_q.size()), 0);
    check("sb6_drained", 32'(exp6_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
